debounce_edge_detect: RTL and testbench
=======================================

# debounce_edge_detect

Conditions a raw, asynchronous single-bit input before it feeds the design's flip-flop stages. The block synchronises the input, filters glitches shorter than a programmable stability window, and produces a clean level. It also produces single-cycle rise/fall pulses and a running count of accepted rising edges. Downstream D-flop stages consume `q`, `rise` and `fall` directly.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops (≥2).
- `STABLE_CYCLES`, default 8: consecutive mismatching cycles required to accept a new level (1 .. 2^CNT_W).
- `CNT_W`, default 4: width of the stability counter.
- `EDGE_W`, default 8: width of the rising-edge counter.
- `clk`  in  1  single clock, all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0); one clock, no other reset.
- `d_in`  in  1  raw asynchronous input.
- `cnt_clr`  in  1  synchronous clear of `edge_count`.
- `q`  out  1  debounced level.
- `rise`  out  1  one-cycle pulse when `q` goes 0→1.
- `fall`  out  1  one-cycle pulse when `q` goes 1→0.
- `busy`  out  1  high while a candidate level change is being qualified.
- `edge_count`  out  EDGE_W  number of accepted rising edges, wraps modulo 2^EDGE_W.

## Operation
- Synchroniser: `d_in` passes through a SYNC_STAGES flop chain; the last stage is `d_sync`. No logic is placed between the stages.
- FSM states:
  - IDLE: `d_sync == q`, stab counter = 0.
  - QUALIFY: `d_sync != q`, stab counter counting.
- FSM transitions, evaluated at each posedge:
  - IDLE → QUALIFY when `d_sync != q`; the stab counter is set to 1.
  - QUALIFY, `d_sync == q` (glitch ended): → IDLE, counter = 0, `q` unchanged, no pulse.
  - QUALIFY, `d_sync != q` and counter == STABLE_CYCLES-1: `q <= d_sync`, counter = 0, → IDLE. `rise` or `fall` is asserted for exactly the following cycle.
  - QUALIFY, otherwise: counter increments.
- STABLE_CYCLES == 1: the IDLE edge that detects the mismatch updates `q` directly. QUALIFY is never entered.
- `busy` = (state == QUALIFY), registered.
- edge_count:
  - Increments on the edge that sets `rise`.
  - `cnt_clr` has priority: `cnt_clr` alone → 0.
  - `cnt_clr` in the same cycle as an accepted rising edge → 1.
  - Wrap-around: 2^EDGE_W-1 + 1 → 0.
- `rise` and `fall` are never high together. Two pulses are always separated by at least STABLE_CYCLES cycles.
- Reset value of every output: `q`, `rise`, `fall` = 0; `busy` = 0; `edge_count` = 0; synchroniser = 0; state = IDLE.
- Reset mid-operation aborts qualification immediately, with no pulse. After release, a held-high input is re-qualified from scratch and produces a `rise`.

## Timing
- Input change settling before edge E1 appears on `d_sync` at edge E(SYNC_STAGES).
- `q`, `rise`/`fall` and `edge_count` update at edge E(SYNC_STAGES + STABLE_CYCLES). With defaults, that is the 10th edge.
- Pulse width is exactly 1 clk.
- `busy` rises at edge E(SYNC_STAGES+1) and falls on the same edge that updates `q` or rejects the glitch.
- A glitch on `d_sync` lasting < STABLE_CYCLES cycles leaves `q` unchanged.
- A glitch lasting exactly STABLE_CYCLES cycles is accepted.
- `cnt_clr` takes effect on the next posedge.
- Reset deassertion is expected to be synchronous to `clk` externally. The block adds no reset synchroniser.

## Test plan
- Reset: hold `reset`=0 with `d_in`=1 for 3 cycles → all outputs 0; release → `rise` pulses at edge 10 after release, `q`=1, `edge_count`=1.
- Clean edges (defaults): `d_in` 0→1 → `busy`=1 from edge 3, `q`=1 and `rise`=1 at edge 10, `rise`=0 at edge 11; then 1→0 → `fall` pulse after 10 edges, `edge_count` stays 1.
- Glitch rejection:
  - `d_in` high for 7 sync cycles then low → `q` stays 0, no pulse, `busy` returns 0.
  - High for exactly 8 cycles → accepted, `rise`=1.
- Counter wrap and clear:
  - EDGE_W=2, 4 accepted rises → `edge_count` 1,2,3,0.
  - `cnt_clr`=1 on the same cycle as a rise → `edge_count`=1.
- Reset mid-qualify: assert `reset` at counter=5 → `busy`=0, `q`=0 instantly; `d_in` held 1 after release → full 10-edge latency to `rise`.
- STABLE_CYCLES=1, SYNC_STAGES=3: `d_in` 0→1 → `q`=1 and `rise` at edge 4; a 1-cycle pulse on `d_in` → `rise` then `fall` 1 cycle apart.

Source files
------------

// File: rtl/debounce_edge_detect.sv
// ============================================================================
// debounce_edge_detect
//
// Cleans up a raw, asynchronous single-bit input so that downstream flops can
// consume it safely. The block does the following:
//   1. Synchronises d_in through a plain SYNC_STAGES flop chain. There is no
//      logic between the stages. The last stage is called d_sync.
//   2. Filters d_sync with a small two-state FSM. A new level is accepted only
//      after d_sync has disagreed with the current clean level for
//      STABLE_CYCLES consecutive clock edges. A shorter excursion is dropped
//      and produces no pulse.
//   3. Emits registered, single-cycle rise/fall pulses on each accepted change.
//   4. Keeps a wrapping count of accepted rising edges, with a synchronous
//      clear.
//
// Parameters
//   SYNC_STAGES   : synchroniser depth. Must be 2 or more.
//   STABLE_CYCLES : consecutive mismatching edges needed to accept a level.
//                   Legal range is 1 .. 2**CNT_W.
//   CNT_W         : width of the stability counter.
//   EDGE_W        : width of the rising-edge counter.
//
// Ports
//   clk        in   single clock; all state updates on posedge
//   reset      in   asynchronous reset, active low (asserted when 0)
//   d_in       in   raw asynchronous input
//   cnt_clr    in   synchronous clear of edge_count
//   q          out  debounced level
//   rise       out  one-cycle pulse on an accepted 0->1 change of q
//   fall       out  one-cycle pulse on an accepted 1->0 change of q
//   busy       out  high while a candidate level change is being qualified
//   edge_count out  number of accepted rising edges, wraps modulo 2**EDGE_W
//
// Reset deassertion must be synchronous to clk. It is aligned outside this
// block.
// ============================================================================
module debounce_edge_detect #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned EDGE_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_in,
    input  logic              cnt_clr,
    output logic              q,
    output logic              rise,
    output logic              fall,
    output logic              busy,
    output logic [EDGE_W-1:0] edge_count
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    // Counter value on the last qualifying edge. The counter reads 1 after the
    // first mismatching edge, so reaching STABLE_CYCLES-1 while still
    // mismatching means this edge is mismatch number STABLE_CYCLES.
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 32'd1);

    // With a one-edge window, the edge that first sees the mismatch accepts it.
    // In that case the FSM never enters QUALIFY.
    localparam bit SINGLE_CYCLE = (STABLE_CYCLES == 32'd1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_stab_cnt;
    logic                   r_q;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_busy;
    logic [EDGE_W-1:0]      r_edge_cnt;

    // ------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------
    logic                   w_d_sync;
    logic                   w_mismatch;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_stab_cnt_nxt;
    logic                   w_q_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic [EDGE_W-1:0]      w_edge_cnt_nxt;

    assign w_d_sync   = r_sync[SYNC_STAGES-1];
    assign w_mismatch = w_d_sync ^ r_q;

    // Synchroniser chain: a pure shift register so that every stage gets a
    // full clock period to resolve metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
        end
    end

    // Debounce FSM next-state, stability counter and pulse decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_stab_cnt_nxt = r_stab_cnt;
        w_q_nxt        = r_q;
        w_rise_nxt     = 1'b0;
        w_fall_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mismatch) begin
                    if (SINGLE_CYCLE) begin
                        // Accept on the detecting edge itself.
                        w_q_nxt        = w_d_sync;
                        w_rise_nxt     = w_d_sync;
                        w_fall_nxt     = ~w_d_sync;
                        w_state_nxt    = ST_IDLE;
                        w_stab_cnt_nxt = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt    = ST_QUALIFY;
                        w_stab_cnt_nxt = CNT_W'(1'b1);
                    end
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_stab_cnt_nxt = {CNT_W{1'b0}};
                end
            end
            ST_QUALIFY: begin
                if (!w_mismatch) begin
                    // The excursion ended before the window filled. Drop it
                    // silently.
                    w_state_nxt    = ST_IDLE;
                    w_stab_cnt_nxt = {CNT_W{1'b0}};
                end else if (r_stab_cnt == STAB_LAST) begin
                    w_q_nxt        = w_d_sync;
                    w_rise_nxt     = w_d_sync;
                    w_fall_nxt     = ~w_d_sync;
                    w_state_nxt    = ST_IDLE;
                    w_stab_cnt_nxt = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt    = ST_QUALIFY;
                    w_stab_cnt_nxt = r_stab_cnt + CNT_W'(1'b1);
                end
            end
            default: begin
                // An illegal encoding falls back to a safe, quiet state.
                w_state_nxt    = ST_IDLE;
                w_stab_cnt_nxt = {CNT_W{1'b0}};
            end
        endcase
    end

    // Edge counter next value. The clear wins, but a rise accepted in the same
    // cycle still counts as one edge.
    always_comb begin
        w_edge_cnt_nxt = r_edge_cnt;
        if (cnt_clr) begin
            if (w_rise_nxt) begin
                w_edge_cnt_nxt = EDGE_W'(1'b1);
            end else begin
                w_edge_cnt_nxt = {EDGE_W{1'b0}};
            end
        end else if (w_rise_nxt) begin
            w_edge_cnt_nxt = r_edge_cnt + EDGE_W'(1'b1);
        end else begin
            w_edge_cnt_nxt = r_edge_cnt;
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_stab_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_stab_cnt <= w_stab_cnt_nxt;
        end
    end

    // Registered outputs. busy tracks the next state, so it rises on the edge
    // that enters QUALIFY. It falls on the same edge that accepts or rejects
    // the change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q        <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_busy     <= 1'b0;
            r_edge_cnt <= {EDGE_W{1'b0}};
        end else begin
            r_q        <= w_q_nxt;
            r_rise     <= w_rise_nxt;
            r_fall     <= w_fall_nxt;
            r_busy     <= (w_state_nxt == ST_QUALIFY);
            r_edge_cnt <= w_edge_cnt_nxt;
        end
    end

    assign q          = r_q;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign busy       = r_busy;
    assign edge_count = r_edge_cnt;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Testbench for debounce_edge_detect. It runs three instances side by side:
//   0: default parameters
//   1: EDGE_W = 2, used for the counter wrap test
//   2: SYNC_STAGES = 3, STABLE_CYCLES = 1
// The reference model keeps the history of d_in values applied since reset
// release. A new level is accepted when the last STABLE_CYCLES synchronised
// samples all differ from the current clean level.
module tb_debounce_edge_detect;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n  [3];
    logic       din    [3];
    logic       clr    [3];
    logic       q_o    [3];
    logic       rise_o [3];
    logic       fall_o [3];
    logic       busy_o [3];
    logic [7:0] ec_a;
    logic [1:0] ec_b;
    logic [7:0] ec_c;

    debounce_edge_detect u_dut0 (
        .clk(clk), .reset(rst_n[0]), .d_in(din[0]), .cnt_clr(clr[0]),
        .q(q_o[0]), .rise(rise_o[0]), .fall(fall_o[0]), .busy(busy_o[0]),
        .edge_count(ec_a));

    debounce_edge_detect #(.EDGE_W(2)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .d_in(din[1]), .cnt_clr(clr[1]),
        .q(q_o[1]), .rise(rise_o[1]), .fall(fall_o[1]), .busy(busy_o[1]),
        .edge_count(ec_b));

    debounce_edge_detect #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) u_dut2 (
        .clk(clk), .reset(rst_n[2]), .d_in(din[2]), .cnt_clr(clr[2]),
        .q(q_o[2]), .rise(rise_o[2]), .fall(fall_o[2]), .busy(busy_o[2]),
        .edge_count(ec_c));

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit hist  [3][8192];
    int hlen  [3];
    bit m_q   [3];
    bit m_rise[3];
    bit m_fall[3];
    bit m_busy[3];
    int m_cnt [3];

    function automatic int ss(int k);
        return (k == 2) ? 3 : 2;
    endfunction

    function automatic int st(int k);
        return (k == 2) ? 1 : 8;
    endfunction

    function automatic int ew(int k);
        return (k == 1) ? 2 : 8;
    endfunction

    function automatic int get_ec(int k);
        case (k)
            0:       return int'(ec_a);
            1:       return int'(ec_b);
            default: return int'(ec_c);
        endcase
    endfunction

    // Synchronised sample seen by the filter at post-release edge n.
    // Edges that precede the history see 0.
    function automatic bit sample(int k, int n);
        int idx;
        idx = n - 1 - ss(k);
        if (idx < 0) return 1'b0;
        return hist[k][idx];
    endfunction

    task automatic apply_reset(int k);
        rst_n[k]  = 1'b0;
        hlen[k]   = 0;
        m_q[k]    = 1'b0;
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        m_busy[k] = 1'b0;
        m_cnt[k]  = 0;
    endtask

    task automatic release_reset(int k);
        rst_n[k] = 1'b1;
    endtask

    // Advance one clock and update the reference models.
    task automatic step();
        bit cur_rst[3];
        bit cur_clr[3];
        bit s;
        bit acc;
        int n;
        for (int k = 0; k < 3; k++) begin
            cur_rst[k] = rst_n[k];
            cur_clr[k] = clr[k];
            if (rst_n[k]) begin
                hist[k][hlen[k]] = din[k];
                hlen[k]++;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (cur_rst[k]) begin
                n = hlen[k];
                s = sample(k, n);
                acc = 1'b1;
                for (int j = 0; j < st(k); j++) begin
                    if (sample(k, n - j) == m_q[k]) acc = 1'b0;
                end
                m_rise[k] = acc && s;
                m_fall[k] = acc && !s;
                if (acc) m_q[k] = s;
                m_busy[k] = (s != m_q[k]);
                if (cur_clr[k]) m_cnt[k] = m_rise[k] ? 1 : 0;
                else if (m_rise[k]) m_cnt[k] = (m_cnt[k] + 1) % (1 << ew(k));
            end
        end
    endtask

    task automatic test_reset();
        apply_reset(0);
        din[0] = 1'b1;
        clr[0] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if ({q_o[0], rise_o[0], fall_o[0], busy_o[0]} !== 4'b0000 || ec_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_hold: q=%b rise=%b fall=%b busy=%b ec=%0d, required all 0",
                     q_o[0], rise_o[0], fall_o[0], busy_o[0], ec_a);
        end
        release_reset(0);
        for (int n = 1; n <= 11; n++) begin
            step();
            checks++;
            if (rise_o[0] !== (n == 10) || q_o[0] !== (n >= 10)) begin
                errors++;
                $display("FAIL reset_release edge %0d: rise=%b q=%b, required rise=%b q=%b",
                         n, rise_o[0], q_o[0], (n == 10), (n >= 10));
            end
        end
        checks++;
        if (ec_a !== 8'd1) begin
            errors++;
            $display("FAIL reset_release_count: ec=%0d, required 1", ec_a);
        end
    endtask

    task automatic test_clean_edges();
        apply_reset(0);
        din[0] = 1'b0;
        step();
        release_reset(0);
        for (int i = 0; i < 3; i++) step();
        din[0] = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            step();
            checks++;
            if (busy_o[0] !== (n >= 3 && n < 10) || q_o[0] !== (n >= 10) || rise_o[0] !== (n == 10)
                || fall_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL clean_rise edge %0d: busy=%b q=%b rise=%b fall=%b, required %b %b %b 0",
                         n, busy_o[0], q_o[0], rise_o[0], fall_o[0], (n >= 3 && n < 10), (n >= 10), (n == 10));
            end
        end
        din[0] = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            step();
            checks++;
            if (fall_o[0] !== (n == 10) || q_o[0] !== (n < 10) || rise_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL clean_fall edge %0d: fall=%b q=%b rise=%b, required %b %b 0",
                         n, fall_o[0], q_o[0], rise_o[0], (n == 10), (n < 10));
            end
        end
        checks++;
        if (ec_a !== 8'd1) begin
            errors++;
            $display("FAIL clean_count: ec=%0d, required 1", ec_a);
        end
    endtask

    task automatic test_glitch();
        int  rises;
        int  falls;
        bit  q_seen;
        bit  busy_seen;
        rises = 0; q_seen = 1'b0; busy_seen = 1'b0;
        din[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 7) din[0] = 1'b0;
            step();
            if (rise_o[0] || fall_o[0]) rises++;
            if (q_o[0]) q_seen = 1'b1;
            if (busy_o[0]) busy_seen = 1'b1;
        end
        checks++;
        if (rises != 0 || q_seen || !busy_seen || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch7: pulses=%0d q_seen=%b busy_seen=%b busy=%b, required 0 0 1 0",
                     rises, q_seen, busy_seen, busy_o[0]);
        end
        rises = 0; falls = 0;
        din[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) din[0] = 1'b0;
            step();
            if (rise_o[0]) rises++;
            if (fall_o[0]) falls++;
        end
        checks++;
        if (rises != 1 || falls != 1) begin
            errors++;
            $display("FAIL glitch8: rises=%0d falls=%0d, required 1 1", rises, falls);
        end
    endtask

    task automatic test_wrap_clear();
        apply_reset(1);
        din[1] = 1'b0;
        clr[1] = 1'b0;
        step();
        release_reset(1);
        for (int r = 1; r <= 5; r++) begin
            din[1] = 1'b1;
            for (int i = 0; i < 12; i++) step();
            checks++;
            if (ec_b !== 2'(r % 4)) begin
                errors++;
                $display("FAIL wrap rise %0d: ec=%0d, required %0d", r, ec_b, r % 4);
            end
            din[1] = 1'b0;
            for (int i = 0; i < 12; i++) step();
        end
        din[1] = 1'b1;
        for (int i = 0; i < 9; i++) step();
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        checks++;
        if (rise_o[1] !== 1'b1 || ec_b !== 2'd1) begin
            errors++;
            $display("FAIL clr_with_rise: rise=%b ec=%0d, required 1 1", rise_o[1], ec_b);
        end
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        checks++;
        if (ec_b !== 2'd0) begin
            errors++;
            $display("FAIL clr_alone: ec=%0d, required 0", ec_b);
        end
    endtask

    task automatic test_reset_mid();
        int rise_at;
        apply_reset(0);
        din[0] = 1'b0;
        step();
        release_reset(0);
        for (int i = 0; i < 3; i++) step();
        din[0] = 1'b1;
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_before: busy=%b, required 1", busy_o[0]);
        end
        apply_reset(0);
        #1;
        checks++;
        if (busy_o[0] !== 1'b0 || q_o[0] !== 1'b0 || rise_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b q=%b rise=%b, required 0 0 0", busy_o[0], q_o[0], rise_o[0]);
        end
        step();
        step();
        release_reset(0);
        rise_at = 0;
        for (int n = 1; n <= 14; n++) begin
            step();
            if (rise_o[0] && rise_at == 0) rise_at = n;
        end
        checks++;
        if (rise_at != 10) begin
            errors++;
            $display("FAIL mid_requalify: rise at edge %0d, required 10", rise_at);
        end
    endtask

    task automatic test_fast();
        int rise_at;
        int fall_at;
        apply_reset(2);
        din[2] = 1'b0;
        clr[2] = 1'b0;
        step();
        release_reset(2);
        for (int i = 0; i < 3; i++) step();
        din[2] = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            checks++;
            if (rise_o[2] !== (n == 4) || q_o[2] !== (n >= 4) || busy_o[2] !== 1'b0) begin
                errors++;
                $display("FAIL fast_rise edge %0d: rise=%b q=%b busy=%b, required %b %b 0",
                         n, rise_o[2], q_o[2], busy_o[2], (n == 4), (n >= 4));
            end
        end
        din[2] = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rise_at = 0; fall_at = 0;
        for (int n = 1; n <= 8; n++) begin
            din[2] = (n == 1);
            step();
            if (rise_o[2] && rise_at == 0) rise_at = n;
            if (fall_o[2] && fall_at == 0) fall_at = n;
        end
        checks++;
        if (rise_at != 4 || fall_at != 5) begin
            errors++;
            $display("FAIL fast_pulse: rise at %0d fall at %0d, required 4 and 5", rise_at, fall_at);
        end
    endtask

    task automatic test_random();
        int run_left[3];
        for (int k = 0; k < 3; k++) begin
            apply_reset(k);
            din[k] = 1'b0;
            clr[k] = 1'b0;
            run_left[k] = 0;
        end
        step();
        for (int k = 0; k < 3; k++) release_reset(k);
        for (int c = 0; c < 900; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (run_left[k] == 0) begin
                    din[k] = 1'($urandom_range(0, 1));
                    run_left[k] = $urandom_range(1, 12);
                end
                run_left[k]--;
                clr[k] = ($urandom_range(0, 15) == 0);
            end
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (q_o[k] !== m_q[k] || rise_o[k] !== m_rise[k] || fall_o[k] !== m_fall[k]
                    || busy_o[k] !== m_busy[k]) begin
                    errors++;
                    $display("FAIL random dut%0d cycle %0d: q/rise/fall/busy=%b%b%b%b, required %b%b%b%b",
                             k, c, q_o[k], rise_o[k], fall_o[k], busy_o[k],
                             m_q[k], m_rise[k], m_fall[k], m_busy[k]);
                end
                checks++;
                if (get_ec(k) != m_cnt[k]) begin
                    errors++;
                    $display("FAIL random_count dut%0d cycle %0d: ec=%0d, required %0d",
                             k, c, get_ec(k), m_cnt[k]);
                end
                checks++;
                if (rise_o[k] === 1'b1 && fall_o[k] === 1'b1) begin
                    errors++;
                    $display("FAIL random_exclusive dut%0d cycle %0d: rise=1 fall=1, required not both", k, c);
                end
            end
        end
        for (int k = 0; k < 3; k++) clr[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            apply_reset(k);
            din[k] = 1'b0;
            clr[k] = 1'b0;
        end
        step();
        step();
        test_reset();
        test_clean_edges();
        test_glitch();
        test_wrap_clear();
        test_reset_mid();
        test_fast();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
